// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline: UART command decode, instruction
// memory loading, run/step control and a register-file/data-memory dump back over UART.
`timescale 1ns/1ps
module debug_unit #(
  parameter int IMEM_WORDS      = 64,
  parameter int DMEM_DUMP_WORDS = 16,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic        o_stop,
  output logic        o_write_instruction_mem,
  output logic [31:0] o_instruction_mem_addr,
  output logic [31:0] o_instruction_mem_data,
  output logic [4:0]  o_r_addr_registers,
  output logic [31:0] o_r_addr_data_mem,
  input  logic [31:0] i_r_data_registers,
  input  logic [31:0] i_r_data_data_mem,
  input  logic        i_end,
  output logic        o_busy
);

  localparam int NUM_ITEMS = 32 + DMEM_DUMP_WORDS;
  localparam int IW        = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int ITW       = $clog2(NUM_ITEMS);
  localparam int DW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_RUN   = 8'h43;
  localparam logic [7:0]  CMD_STEP  = 8'h53;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_BYTES = 4'd1,
    S_LOAD_WRITE = 4'd2,
    S_RUN        = 4'd3,
    S_DRAIN      = 4'd4,
    S_STEP       = 4'd5,
    S_DUMP_SETUP = 4'd6,
    S_DUMP_SEND  = 4'd7,
    S_DUMP_WAIT  = 4'd8
  } state_t;

  state_t          r_state;
  logic [31:0]     r_word;
  logic [1:0]      r_byte_cnt;
  logic [IW-1:0]   r_word_idx;
  logic [ITW-1:0]  r_item;
  logic [DW-1:0]   r_drain_cnt;
  logic [31:0]     r_dump_word;

  logic [31:0]     w_next_word;
  logic            w_last_item;
  logic            w_last_imem;

  function automatic logic [4:0] f_reg_addr(input logic [ITW-1:0] item);
    if (item < ITW'(32)) f_reg_addr = item[4:0];
    else                 f_reg_addr = 5'd0;
  endfunction

  // Dump items past the register file map onto consecutive data-memory words from byte 0.
  function automatic logic [31:0] f_mem_addr(input logic [ITW-1:0] item);
    if (item < ITW'(32)) f_mem_addr = 32'd0;
    else                 f_mem_addr = (32'(item) - 32'd32) << 2;
  endfunction

  function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    f_byte = word[31:24];
      2'd1:    f_byte = word[23:16];
      2'd2:    f_byte = word[15:8];
      default: f_byte = word[7:0];
    endcase
  endfunction

  assign w_next_word = {r_word[23:0], i_rx_data};
  assign w_last_item = (r_item == ITW'(NUM_ITEMS - 1));
  assign w_last_imem = (r_word_idx == IW'(IMEM_WORDS - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state                 <= S_IDLE;
      r_word                  <= 32'd0;
      r_byte_cnt              <= 2'd0;
      r_word_idx              <= '0;
      r_item                  <= '0;
      r_drain_cnt             <= '0;
      r_dump_word             <= 32'd0;
      o_tx_data               <= 8'd0;
      o_tx_start              <= 1'b0;
      o_stop                  <= 1'b1;
      o_write_instruction_mem <= 1'b0;
      o_instruction_mem_addr  <= 32'd0;
      o_instruction_mem_data  <= 32'd0;
      o_r_addr_registers      <= 5'd0;
      o_r_addr_data_mem       <= 32'd0;
      o_busy                  <= 1'b0;
    end else begin
      o_tx_start              <= 1'b0;
      o_write_instruction_mem <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                r_state    <= S_LOAD_BYTES;
                r_byte_cnt <= 2'd0;
                o_busy     <= 1'b1;
              end
              CMD_RUN: begin
                o_busy <= 1'b1;
                if (i_end) begin
                  r_state <= S_DUMP_SETUP;
                end else begin
                  r_state <= S_RUN;
                  o_stop  <= 1'b0;
                end
              end
              CMD_STEP: begin
                o_busy <= 1'b1;
                if (i_end) begin
                  r_state <= S_DUMP_SETUP;
                end else begin
                  r_state <= S_STEP;
                  o_stop  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        S_LOAD_BYTES: begin
          if (i_rx_valid) begin
            r_word     <= w_next_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state                 <= S_LOAD_WRITE;
              o_write_instruction_mem <= 1'b1;
              o_instruction_mem_addr  <= {{(30-IW){1'b0}}, r_word_idx, 2'b00};
              o_instruction_mem_data  <= w_next_word;
            end
          end
        end
        S_LOAD_WRITE: begin
          if ((r_word == HALT_WORD) || w_last_imem) begin
            r_word_idx <= '0;
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
          end else begin
            r_word_idx <= r_word_idx + IW'(1);
            r_state    <= S_LOAD_BYTES;
          end
        end
        S_RUN: begin
          if (i_end) begin
            if (DRAIN_CYCLES == 0) begin
              o_stop  <= 1'b1;
              r_state <= S_DUMP_SETUP;
            end else begin
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            o_stop  <= 1'b1;
            r_state <= S_DUMP_SETUP;
          end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
          end
        end
        S_STEP: begin
          o_stop  <= 1'b1;
          r_state <= S_DUMP_SETUP;
        end
        S_DUMP_SETUP: begin
          r_dump_word <= (r_item < ITW'(32)) ? i_r_data_registers : i_r_data_data_mem;
          r_byte_cnt  <= 2'd0;
          r_state     <= S_DUMP_SEND;
        end
        S_DUMP_SEND: begin
          o_tx_data  <= f_byte(r_dump_word, r_byte_cnt);
          o_tx_start <= 1'b1;
          r_state    <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          // o_tx_data is only rewritten in DUMP_SEND, so it stays stable while waiting.
          if (i_tx_done) begin
            if (r_byte_cnt == 2'd3) begin
              if (w_last_item) begin
                r_item             <= '0;
                o_r_addr_registers <= 5'd0;
                o_r_addr_data_mem  <= 32'd0;
                o_busy             <= 1'b0;
                r_state            <= S_IDLE;
              end else begin
                r_item             <= r_item + ITW'(1);
                o_r_addr_registers <= f_reg_addr(r_item + ITW'(1));
                o_r_addr_data_mem  <= f_mem_addr(r_item + ITW'(1));
                r_state            <= S_DUMP_SETUP;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_state    <= S_DUMP_SEND;
            end
          end
        end
        default: begin
          o_stop  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side controller for the MIPS pipeline. Consumes command bytes from a UART receiver, loads the instruction memory, and runs the pipeline in continuous or single-step mode.
- After each run or step it serialises the register file and a data-memory window back to a UART transmitter.
- Sits between the uart rx/tx blocks and the pipeline debug ports (i_stop, i_write_instruction_mem, i_instruction_mem_addr/data, i_r_addr_registers, i_r_addr_data_mem, o_end).

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words.
- DMEM_DUMP_WORDS, 16, data-memory words dumped, starting at byte address 0.
- DRAIN_CYCLES, 3, extra clocks run after i_end before stopping (lets in-flight instructions retire).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle strobe; starts a transmission.
- i_tx_done  in  1  one-cycle strobe; transmitter finished the byte.
- o_stop  out  1  pipeline freeze (to pipeline i_stop).
- o_write_instruction_mem  out  1  instruction memory write enable.
- o_instruction_mem_addr  out  32  instruction memory byte address.
- o_instruction_mem_data  out  32  instruction word.
- o_r_addr_registers  out  5  register-file debug read address.
- o_r_addr_data_mem  out  32  data-memory debug read byte address.
- i_r_data_registers  in  32  register-file read data (combinational, valid same cycle).
- i_r_data_data_mem  in  32  data-memory read data (combinational, valid same cycle).
- i_end  in  1  pipeline has retired HALT (level).
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0 except o_stop=1. FSM=IDLE; word/byte counters 0.
- Commands are accepted only in IDLE: 'L'(0x4C) load, 'C'(0x43) continuous run, 'S'(0x53) step. Any other byte is ignored. Bytes arriving outside IDLE/LOAD_BYTES are dropped.
- o_stop=1 in every state except RUN, DRAIN and the single STEP cycle.
- LOAD:
  - IDLE -'L'-> LOAD_BYTES. Collects 4 bytes MSB-first into the word.
  - On the 4th byte -> LOAD_WRITE (1 cycle): o_write_instruction_mem=1, addr=word_idx*4, data=word. Then word_idx++.
  - If word==0xFFFFFFFF (HALT) or word_idx reaches IMEM_WORDS: word_idx clears -> IDLE. Otherwise -> LOAD_BYTES.
  - HALT is itself written. No wrap-around.
- RUN:
  - IDLE -'C'-> RUN with o_stop=0.
  - When i_end is sampled high -> DRAIN for DRAIN_CYCLES clocks with o_stop=0, then o_stop=1 -> DUMP.
  - If i_end is already high at the command: no cycles run; go directly to DUMP.
- STEP:
  - IDLE -'S'-> STEP: o_stop=0 for exactly one clock -> DUMP.
  - If i_end is already high, o_stop stays 1 and the step cycle is skipped.
- DUMP sequence:
  - Items 0..31: register i, using o_r_addr_registers=i.
  - Then items 0..DMEM_DUMP_WORDS-1: data word, using o_r_addr_data_mem=4*k.
  - Per item: DUMP_SETUP drives the address for 1 cycle, then latches the 32-bit read data.
  - DUMP_SEND pulses o_tx_start with byte 3 (MSB) first. DUMP_WAIT waits for i_tx_done, then advances to the next byte.
  - After the last byte of the last item -> IDLE. Total bytes = 4*(32+DMEM_DUMP_WORDS) = 192 at defaults.
  - o_tx_data is held stable from o_tx_start until i_tx_done.
- Simultaneous events: i_rx_valid in the same cycle the FSM returns to IDLE is dropped. i_end during STEP is ignored (the step completes normally).
- Reset mid-operation: immediately returns to the reset state. Any partial word is discarded and o_stop is asserted within the same cycle (asynchronous).

Test Plan:
- Load: send 'L', then ADDI 0x20A60004 as bytes 20 A6 00 04, then FF FF FF FF -> exactly two write pulses: addr 0 data 0x20A60004, addr 4 data 0xFFFFFFFF. o_busy returns to 0.
- Run: load the ADDI/SW/LW/ORI/J/loop program ending in HALT at addr 72, send 'C' -> o_stop low until i_end+3 clocks. Dump yields 192 bytes: reg1 = 00 00 00 04, reg6 = 00 00 00 06, mem word 1 (addr 4) = 00 00 00 04.
- Step: after load send 'S' -> o_stop low exactly 1 cycle, then 192 bytes dumped. Repeat 'S' 3 times -> the pipeline has advanced exactly 3 cycles.
- Backpressure: delay i_tx_done by 50 cycles per byte -> no extra o_tx_start pulses, byte order preserved, o_tx_data stable throughout.
- Boundaries: send 'X' in IDLE -> ignored. With IMEM_WORDS=4, load 5 non-HALT words -> 4 writes (addrs 0..12) then IDLE; the 5th word's bytes are ignored as commands except 'L'/'C'/'S' values. 'C' with i_end already high -> dump starts with no o_stop=0 cycle.
- Reset: assert i_reset after 2 bytes of a load word and during a dump -> outputs at reset values immediately (o_stop=1). A subsequent clean load starts at addr 0.
